switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default noc_params::BUFFER_SIZE (8): downstream per-VC buffer depth and initial credit count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port request_i  input  [PORT_NUM][VC_NUM]  input VC (p,v) holds a flit ready to traverse the crossbar.
REQ-005 SHALL have port out_port_i  input  [PORT_NUM][VC_NUM] x port_t  routed output port of input VC (p,v).
REQ-006 SHALL have port downstream_vc_i  input  [PORT_NUM][VC_NUM] x VC_SIZE  downstream VC already allocated to input VC (p,v).
REQ-007 SHALL have port credit_i  input  [PORT_NUM][VC_NUM]  one credit returned for output port o, downstream VC d.
REQ-008 SHALL have port grant_o  output  [PORT_NUM][VC_NUM]  registered grant; at most one bit set per input port.
REQ-009 SHALL have port xbar_sel_o  output  [PORT_NUM] x port_t  per output port, the selected input port.
REQ-010 SHALL have port valid_o  output  [PORT_NUM]  output port o carries a granted flit this cycle.

Function
REQ-011 SHALL perform separable input-first allocation: stage 1 picks one VC per input port, stage 2 picks one input port per output port.
REQ-012 Stage 1 SHALL consider (p,v) eligible only if request_i set, out_port_i < PORT_NUM, and (with credit check compiled in) credit[out_port_i][downstream_vc_i] > 0.
REQ-013 Stage 1 and stage 2 SHALL each use a round-robin arbiter with priority starting at pointer; the lowest index wins when pointer is 0.
REQ-014 A stage-1 pointer SHALL advance to (winner+1) mod VC_NUM only when that winner also wins stage 2; otherwise it is held.
REQ-015 A stage-2 pointer SHALL advance to (winner+1) mod PORT_NUM on every stage-2 grant and be held when no grant occurs.
REQ-016 grant_o, xbar_sel_o, valid_o SHALL be registered, giving one-cycle latency from request to grant; a request in cycle t yields its grant in cycle t+1.
REQ-017 Per output port o, xbar_sel_o[o] SHALL equal the granting input port and valid_o[o]=1; with valid_o[o]=0, xbar_sel_o[o] SHALL be LOCAL.
REQ-018 Credit counters [PORT_NUM][VC_NUM], width $clog2(BUFFER_SIZE+1), SHALL decrement on the same edge that registers a grant to (o,d).
REQ-019 A counter SHALL increment on credit_i[o][d]; a simultaneous grant and credit SHALL leave it unchanged.
REQ-020 A counter SHALL never exceed BUFFER_SIZE; a credit arriving at BUFFER_SIZE SHALL be dropped (saturate).
REQ-021 A counter SHALL never go below 0; with the count at 0, no grant to (o,d) SHALL occur.
REQ-022 No requests SHALL produce all-zero outputs next cycle, with pointers and counters unchanged apart from returning credits.

Reset
REQ-023 On rst low, all outputs SHALL be 0 (xbar_sel_o = LOCAL) immediately and asynchronously.
REQ-024 On rst low, all pointers SHALL be 0 and all credit counters SHALL be BUFFER_SIZE.
REQ-025 credit_i asserted while rst is low SHALL be ignored.
REQ-026 The first grant after release SHALL occur no earlier than the cycle after the first rising edge with rst high.

Configuration
REQ-027 Macro SA_CREDIT_CHECK_EN defined: credit counters are instantiated and gate eligibility per REQ-012 and REQ-018 to REQ-021.
REQ-028 SA_CREDIT_CHECK_EN undefined: no counters exist, credit_i is ignored, and eligibility depends only on request_i and out_port_i.

Structure
REQ-029 BUFFER_SIZE SHALL be a localparam in noc_params; port_t, PORT_NUM, VC_NUM and VC_SIZE SHALL be reused from it.
REQ-030 A sub-module round_robin_arbiter #(N) (request vector, pointer input, one-hot grant plus index output, combinational) SHALL be instantiated PORT_NUM times with N=VC_NUM and PORT_NUM times with N=PORT_NUM.

Verification
REQ-031 Single request: (1,0) set, out_port EAST, dvc 1 -> next cycle grant_o[1][0]=1, valid_o[EAST]=1, xbar_sel_o[EAST]=NORTH, credit[EAST][1]=7.
REQ-032 Contention: inputs NORTH, SOUTH, WEST VC0 all target LOCAL, held 6 cycles -> grants rotate NORTH, SOUTH, WEST, NORTH, SOUTH, WEST.
REQ-033 Credit exhaustion: one VC requests EAST/dvc0 continuously, no credits -> exactly 8 grants, then none; one credit_i pulse -> exactly one further grant.
REQ-034 Simultaneous grant and credit on the same (o,d) at count 3 -> count stays 3; credit at count 8 -> count stays 8.
REQ-035 Input VCs 0 and 1 target different outputs, VC0 loses stage 2 -> stage-1 pointer stays 0; VC0 retried next cycle ahead of VC1.
REQ-036 Assert rst mid-traffic -> outputs 0 within the same cycle and counters 8; build without SA_CREDIT_CHECK_EN -> REQ-033 stimulus grants every cycle.

Source files
------------

// File: rtl/noc_params.sv
// noc_params: shared router dimensions, port encoding and buffer depth.
package noc_params;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM = 2;
  localparam int VC_SIZE = $clog2(VC_NUM);
  localparam int BUFFER_SIZE = 8;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
  localparam int PORT_SIZE = $bits(port_t);
endpackage

// File: rtl/switch_allocator_rr.sv
// round_robin_arbiter: combinational round-robin pick, priority starting at ptr_i.
module round_robin_arbiter #(
  parameter int N = 4,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] j;
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = W'((int'(ptr_i) + i) % N);
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: separable input-first VC/port allocator with registered grants.
// Define SA_CREDIT_CHECK_EN to add downstream credit counters that gate eligibility.
module switch_allocator
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]   request_i,
  input  port_t                             out_port_i [PORT_NUM][VC_NUM],
  input  logic [VC_SIZE-1:0]                downstream_vc_i [PORT_NUM][VC_NUM],
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]   credit_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]   grant_o,
  output port_t                             xbar_sel_o [PORT_NUM],
  output logic [PORT_NUM-1:0]               valid_o
);
  logic [PORT_NUM-1:0][VC_NUM-1:0] elig, vc_gnt, has_cr, grant_d, grant_q;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] vc_idx, ptr1_d, ptr1_q;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] in_idx, ptr2_d, ptr2_q;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] in_req, in_gnt;
  logic [PORT_NUM-1:0] s1_vld, won, valid_d, valid_q;
  port_t s1_out [PORT_NUM];
  port_t xbar_d [PORT_NUM];
  port_t xbar_q [PORT_NUM];
`ifdef SA_CREDIT_CHECK_EN
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  logic [CW-1:0] cnt_q [PORT_NUM][VC_NUM];
  logic [CW-1:0] cnt_d [PORT_NUM][VC_NUM];
  logic [PORT_NUM-1:0][VC_NUM-1:0] dec;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] s1_dvc;
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        has_cr[p][v] = int'(out_port_i[p][v]) < PORT_NUM &&
                       cnt_q[out_port_i[p][v]][downstream_vc_i[p][v]] != '0;
  end
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) s1_dvc[p] = downstream_vc_i[p][vc_idx[p]];
  end
  // A grant and a returning credit on the same edge cancel out.
  always_comb begin
    dec = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int d = 0; d < VC_NUM; d++) begin
        for (int p = 0; p < PORT_NUM; p++)
          dec[o][d] = dec[o][d] | (won[p] && int'(s1_out[p]) == o && int'(s1_dvc[p]) == d);
        cnt_d[o][d] = dec[o][d] && !credit_i[o][d] ? cnt_q[o][d] - 1'b1 :
                      credit_i[o][d] && !dec[o][d] && cnt_q[o][d] < CW'(BUFFER_SIZE) ? cnt_q[o][d] + 1'b1 :
                      cnt_q[o][d];
      end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < PORT_NUM; o++)
        for (int d = 0; d < VC_NUM; d++) cnt_q[o][d] <= CW'(BUFFER_SIZE);
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_in;
  assign has_cr = '1;
  always_comb begin
    unused_in = ^credit_i;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) unused_in = unused_in ^ (^downstream_vc_i[p][v]);
  end
`endif
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        elig[p][v] = request_i[p][v] && int'(out_port_i[p][v]) < PORT_NUM && has_cr[p][v];
  end
  for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
    round_robin_arbiter #(.N(VC_NUM)) u_vc (
      .req_i(elig[g]), .ptr_i(ptr1_q[g]), .gnt_o(vc_gnt[g]), .idx_o(vc_idx[g])
    );
    round_robin_arbiter #(.N(PORT_NUM)) u_in (
      .req_i(in_req[g]), .ptr_i(ptr2_q[g]), .gnt_o(in_gnt[g]), .idx_o(in_idx[g])
    );
  end
  always_comb begin
    in_req = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      s1_vld[p] = |elig[p];
      s1_out[p] = out_port_i[p][vc_idx[p]];
      for (int o = 0; o < PORT_NUM; o++) in_req[o][p] = s1_vld[p] && int'(s1_out[p]) == o;
    end
  end
  always_comb begin
    won = '0;
    for (int o = 0; o < PORT_NUM; o++) won = won | in_gnt[o];
  end
  // Stage-1 pointer only moves when its winner also clears stage 2.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      grant_d[p] = won[p] ? vc_gnt[p] : '0;
      ptr1_d[p] = won[p] ? VC_SIZE'((int'(vc_idx[p]) + 1) % VC_NUM) : ptr1_q[p];
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      valid_d[o] = |in_req[o];
      xbar_d[o] = valid_d[o] ? port_t'(in_idx[o]) : LOCAL;
      ptr2_d[o] = valid_d[o] ? PORT_SIZE'((int'(in_idx[o]) + 1) % PORT_NUM) : ptr2_q[o];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      valid_q <= '0;
      ptr1_q <= '0;
      ptr2_q <= '0;
      for (int o = 0; o < PORT_NUM; o++) xbar_q[o] <= LOCAL;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr1_q <= ptr1_d;
      ptr2_q <= ptr2_d;
      xbar_q <= xbar_d;
    end
  end
  assign grant_o = grant_q;
  assign valid_o = valid_q;
  assign xbar_sel_o = xbar_q;
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed scoreboard bench; credit expectations follow SA_CREDIT_CHECK_EN.
module tb_switch_allocator;
  import noc_params::*;
`ifdef SA_CREDIT_CHECK_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [PORT_NUM-1:0][VC_NUM-1:0] request_i, credit_i, grant_o;
  port_t out_port [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0] dvc [PORT_NUM][VC_NUM];
  port_t xbar [PORT_NUM];
  logic [PORT_NUM-1:0] valid_o;
  typedef struct {
    string tag;
    logic [PORT_NUM-1:0][VC_NUM-1:0] g;
    logic [PORT_NUM-1:0] v;
    logic [3*PORT_NUM-1:0] x;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk(clk), .rst(rst), .request_i(request_i), .out_port_i(out_port),
    .downstream_vc_i(dvc), .credit_i(credit_i), .grant_o(grant_o),
    .xbar_sel_o(xbar), .valid_o(valid_o)
  );

  task automatic push(string tag, bit hit, int p, int vc, int o);
    exp_t e;
    e.tag = tag;
    e.g = '0;
    e.v = '0;
    e.x = '0;
    if (hit) begin
      e.g[p][vc] = 1'b1;
      e.v[o] = 1'b1;
      e.x[o*3+:3] = 3'(p);
    end
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [3*PORT_NUM-1:0] xo;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: got 0 pending entries, required at least 1");
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int o = 0; o < PORT_NUM; o++) xo[o*3+:3] = xbar[o];
    checks++;
    assert (grant_o === e.g) else begin
      errors++;
      $error("FAIL %s grant: got %h required %h", e.tag, grant_o, e.g);
    end
    checks++;
    assert (valid_o === e.v) else begin
      errors++;
      $error("FAIL %s valid: got %b required %b", e.tag, valid_o, e.v);
    end
    checks++;
    assert (xo === e.x) else begin
      errors++;
      $error("FAIL %s xbar: got %h required %h", e.tag, xo, e.x);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic clear();
    request_i = '0;
    credit_i = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) begin
        out_port[p][v] = LOCAL;
        dvc[p][v] = '0;
      end
  endtask

  task automatic req(int p, int vc, port_t o, int d);
    request_i[p][vc] = 1'b1;
    out_port[p][vc] = o;
    dvc[p][vc] = VC_SIZE'(d);
  endtask

  initial begin
    clear();
    #1;
    push("reset", 0, 0, 0, 0);
    check();
    req(1, 0, EAST, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      push("in_reset", 0, 0, 0, 0);
      check();
    end
    rst = 1'b1;
    push("single", 1, 1, 0, EAST);
    cycle();
    clear();
    push("idle", 0, 0, 0, 0);
    cycle();
    req(1, 0, LOCAL, 0);
    req(2, 0, LOCAL, 0);
    req(3, 0, LOCAL, 0);
    for (int i = 0; i < 6; i++) begin
      push("contend", 1, 1 + i % 3, 0, LOCAL);
      cycle();
    end
    clear();
    req(0, 0, NORTH, 0);
    req(4, 0, NORTH, 0);
    req(4, 1, SOUTH, 0);
    push("s1_lose", 1, 0, 0, NORTH);
    cycle();
    request_i[0][0] = 1'b0;
    push("s1_retry", 1, 4, 0, NORTH);
    cycle();
    push("s1_next", 1, 4, 1, SOUTH);
    cycle();
    clear();
    request_i[2][0] = 1'b1;
    out_port[2][0] = port_t'(3'd6);
    push("bad_port", 0, 0, 0, 0);
    cycle();
    clear();
    req(3, 0, EAST, 0);
    for (int i = 0; i < 10; i++) begin
      push("exhaust", !CC || i < 8, 3, 0, EAST);
      cycle();
    end
    credit_i[EAST][0] = 1'b1;
    push("credit_pulse", !CC, 3, 0, EAST);
    cycle();
    credit_i = '0;
    push("credit_grant", 1, 3, 0, EAST);
    cycle();
    push("credit_spent", !CC, 3, 0, EAST);
    cycle();
    clear();
    req(1, 0, LOCAL, 0);
    req(2, 0, LOCAL, 0);
    req(3, 0, LOCAL, 0);
    push("pre_reset", 1, 1, 0, LOCAL);
    cycle();
    #2 rst = 1'b0;
    #1;
    push("async_reset", 0, 0, 0, 0);
    check();
    @(posedge clk);
    #1;
    push("held_reset", 0, 0, 0, 0);
    check();
    rst = 1'b1;
    push("post_reset", 1, 1, 0, LOCAL);
    cycle();
    clear();
    credit_i[EAST][0] = 1'b1;
    repeat (2) begin
      push("sat_credit", 0, 0, 0, 0);
      cycle();
    end
    credit_i = '0;
    req(3, 0, EAST, 0);
    for (int i = 0; i < 10; i++) begin
      push("refill", !CC || i < 8, 3, 0, EAST);
      cycle();
    end
    clear();
    credit_i[EAST][0] = 1'b1;
    repeat (3) begin
      push("credit_back", 0, 0, 0, 0);
      cycle();
    end
    req(3, 0, EAST, 0);
    repeat (4) begin
      push("grant_and_credit", 1, 3, 0, EAST);
      cycle();
    end
    credit_i = '0;
    for (int i = 0; i < 5; i++) begin
      push("drain", !CC || i < 3, 3, 0, EAST);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
